pipeline_regs: RTL and testbench
================================

// Module: pipeline_regs
// PURPOSE
//   Holds the three inter-stage registers of the 5-stage in-order 16-bit CPU: IF/ID, ID/EX, EX/MEM.
//   Each stage captures its upstream bundle on the rising clock edge and presents it to the next stage.
//   The block sits between if_pc/ROM, id, ex_alu and mem. It has no stall or flush.
// PARAMETERS
//   INST_ADDR_W  16  PC / instruction address width
//   INST_W       16  instruction word width
//   REG_W        16  register data width
//   REG_ADDR_W   4   register-file address width (16 registers)
//   ALUOP_W      8   ALU operation code width
//   ALUSEL_W     3   ALU result-select width
// PORTS
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous, active-high reset
//   if_pc_i     in   INST_ADDR_W  PC from fetch
//   if_inst_i   in   INST_W       instruction word from ROM
//   id_pc_o     out  INST_ADDR_W  registered PC to decode
//   id_inst_o   out  INST_W       registered instruction to decode
//   id_aluop_i  in   ALUOP_W      decoded ALU op
//   id_alusel_i in   ALUSEL_W     decoded ALU select
//   id_reg1_i   in   REG_W        operand 1 (already forwarded)
//   id_reg2_i   in   REG_W        operand 2 (already forwarded)
//   id_wd_i     in   REG_ADDR_W   destination register
//   id_wreg_i   in   1            destination write enable
//   ex_aluop_o  out  ALUOP_W      registered ALU op
//   ex_alusel_o out  ALUSEL_W     registered ALU select
//   ex_reg1_o   out  REG_W        registered operand 1
//   ex_reg2_o   out  REG_W        registered operand 2
//   ex_wd_o     out  REG_ADDR_W   registered destination register
//   ex_wreg_o   out  1            registered write enable
//   ex_wd_i     in   REG_ADDR_W   ALU destination register
//   ex_wreg_i   in   1            ALU write enable
//   ex_wdata_i  in   REG_W        ALU result
//   mem_wd_o    out  REG_ADDR_W   registered destination register
//   mem_wreg_o  out  1            registered write enable
//   mem_wdata_o out  REG_W        registered result
// BEHAVIOUR
//   - Single clock domain. All state updates on posedge clk; no combinational path from any input to any output.
//   - Reset (rst=1 sampled at posedge): every output goes to 0. ALUOP=0 and ALUSEL=0 encode NOP and wreg=0,
//     so a reset stage is a bubble.
//   - While rst stays high, outputs hold 0 regardless of inputs. The first capture is at the first edge with rst=0.
//   - Reset asserted mid-operation: all three stages clear at that same edge.
//     In-flight data is discarded; there is no partial clear.
//   - No reset effect between edges (synchronous only).
//   - Normal operation: each stage output = its input bundle sampled at the previous edge (latency exactly 1 cycle).
//   - IF/ID: {id_pc_o,id_inst_o} <= {if_pc_i,if_inst_i}.
//   - ID/EX: {ex_aluop_o,ex_alusel_o,ex_reg1_o,ex_reg2_o,ex_wd_o,ex_wreg_o} <= matching id_*_i.
//   - EX/MEM: {mem_wd_o,mem_wreg_o,mem_wdata_o} <= {ex_wd_i,ex_wreg_i,ex_wdata_i}.
//   - Stages are independent. The block does no chaining; id and ex_alu sit between the stages externally.
//   - Fields are bit-exact copies: no width change, sign extension or masking.
//     wd is captured even when wreg=0.
//   - No stall/flush/enable: every non-reset edge captures.
// STRUCTURE
//   - Shared package cpu_pkg: the width constants above, plus RST_ENABLE=1'b1, ZERO_WORD, NOP_ALUOP and NOP_ALUSEL.
//   - One generic sub-module pipe_reg #(W): W-bit register with synchronous active-high clear to 0.
//     Instantiate it once per stage on the concatenated bundle.
// TESTING
//   1. Hold rst=1 for 2 cycles with if_inst_i=16'h3443 and if_pc_i=16'h0005 -> all outputs 0 throughout.
//   2. Release rst, if_pc_i=16'h0001, if_inst_i=16'h3443 -> after 1 edge id_pc_o=16'h0001 and id_inst_o=16'h3443;
//      outputs unchanged before the edge.
//   3. id_reg1_i=16'h0033, id_reg2_i=16'h0029, id_wd_i=4'h3, id_wreg_i=1, id_aluop_i=8'h25 -> next edge ex_* equal
//      these; change inputs mid-cycle -> ex_* unchanged until the next edge.
//   4. ex_wdata_i=16'hFFFF, ex_wd_i=4'hF, ex_wreg_i=1 -> next edge mem_wdata_o=16'hFFFF, mem_wd_o=4'hF, mem_wreg_o=1.
//   5. Streaming: new if_pc_i each cycle 0..9 -> id_pc_o is the same sequence delayed by exactly 1 cycle.
//   6. Assert rst for one cycle with all stages loaded (nonzero) -> all outputs 0 after that edge;
//      the next edge reloads from the inputs.

Source files
------------

// File: rtl/pipeline_regs_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared widths, reset polarity and stage bundle types for the CPU
// Revision: 1.0
// ============================================================================
package cpu_pkg;

   localparam int INST_ADDR_W = 16;
   localparam int INST_W      = 16;
   localparam int REG_W       = 16;
   localparam int REG_ADDR_W  = 4;
   localparam int ALUOP_W     = 8;
   localparam int ALUSEL_W    = 3;

   localparam logic                RST_ENABLE = 1'b1;
   localparam logic [REG_W-1:0]    ZERO_WORD  = '0;
   localparam logic [ALUOP_W-1:0]  NOP_ALUOP  = '0;
   localparam logic [ALUSEL_W-1:0] NOP_ALUSEL = '0;

   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } if_id_t;

   typedef struct packed {
      logic [ALUOP_W-1:0]    aluop;
      logic [ALUSEL_W-1:0]   alusel;
      logic [REG_W-1:0]      reg1;
      logic [REG_W-1:0]      reg2;
      logic [REG_ADDR_W-1:0] wd;
      logic                  wreg;
   } id_ex_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wd;
      logic                  wreg;
      logic [REG_W-1:0]      wdata;
   } ex_mem_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_regs_if.sv
`default_nettype none
// ============================================================================
// pipeline_regs_if : stage-boundary signals between fetch/id/ex/mem and regs
// Revision: 1.0
// ============================================================================
interface pipeline_regs_if;
   import cpu_pkg::*;

   logic [INST_ADDR_W-1:0] if_pc_i;
   logic [INST_W-1:0]      if_inst_i;
   logic [INST_ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0]      id_inst_o;

   logic [ALUOP_W-1:0]     id_aluop_i;
   logic [ALUSEL_W-1:0]    id_alusel_i;
   logic [REG_W-1:0]       id_reg1_i;
   logic [REG_W-1:0]       id_reg2_i;
   logic [REG_ADDR_W-1:0]  id_wd_i;
   logic                   id_wreg_i;
   logic [ALUOP_W-1:0]     ex_aluop_o;
   logic [ALUSEL_W-1:0]    ex_alusel_o;
   logic [REG_W-1:0]       ex_reg1_o;
   logic [REG_W-1:0]       ex_reg2_o;
   logic [REG_ADDR_W-1:0]  ex_wd_o;
   logic                   ex_wreg_o;

   logic [REG_ADDR_W-1:0]  ex_wd_i;
   logic                   ex_wreg_i;
   logic [REG_W-1:0]       ex_wdata_i;
   logic [REG_ADDR_W-1:0]  mem_wd_o;
   logic                   mem_wreg_o;
   logic [REG_W-1:0]       mem_wdata_o;

   // Master drives the stage inputs and observes the registered outputs.
   modport master (
      output if_pc_i, if_inst_i,
      output id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
      output ex_wd_i, ex_wreg_i, ex_wdata_i,
      input  id_pc_o, id_inst_o,
      input  ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
      input  mem_wd_o, mem_wreg_o, mem_wdata_o
   );

   modport slave (
      input  if_pc_i, if_inst_i,
      input  id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
      input  ex_wd_i, ex_wreg_i, ex_wdata_i,
      output id_pc_o, id_inst_o,
      output ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
      output mem_wd_o, mem_wreg_o, mem_wdata_o
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_regs_pipe_reg.sv
`default_nettype none
// ============================================================================
// pipe_reg : W-bit register, captures every edge, synchronous clear to zero
// Revision: 1.0
// ============================================================================
module pipe_reg
   import cpu_pkg::*;
#(
   parameter int W = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [W-1:0] i_d,
   output logic      [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_q <= '0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_regs.sv
`default_nettype none
// ============================================================================
// pipeline_regs : IF/ID, ID/EX and EX/MEM registers; zero on reset is a bubble
// Revision: 1.0
// ============================================================================
module pipeline_regs
   import cpu_pkg::*;
(
   input  wire logic      clk,
   input  wire logic      rst,
   pipeline_regs_if.slave bus
);

   if_id_t  w_if_id_d,  w_if_id_q;
   id_ex_t  w_id_ex_d,  w_id_ex_q;
   ex_mem_t w_ex_mem_d, w_ex_mem_q;

   assign w_if_id_d  = {bus.if_pc_i, bus.if_inst_i};
   assign w_id_ex_d  = {bus.id_aluop_i, bus.id_alusel_i, bus.id_reg1_i,
                        bus.id_reg2_i, bus.id_wd_i, bus.id_wreg_i};
   assign w_ex_mem_d = {bus.ex_wd_i, bus.ex_wreg_i, bus.ex_wdata_i};

   pipe_reg #(.W($bits(if_id_t))) u_if_id (
      .clk (clk),
      .rst (rst),
      .i_d (w_if_id_d),
      .o_q (w_if_id_q)
   );

   pipe_reg #(.W($bits(id_ex_t))) u_id_ex (
      .clk (clk),
      .rst (rst),
      .i_d (w_id_ex_d),
      .o_q (w_id_ex_q)
   );

   pipe_reg #(.W($bits(ex_mem_t))) u_ex_mem (
      .clk (clk),
      .rst (rst),
      .i_d (w_ex_mem_d),
      .o_q (w_ex_mem_q)
   );

   assign bus.id_pc_o     = w_if_id_q.pc;
   assign bus.id_inst_o   = w_if_id_q.inst;

   assign bus.ex_aluop_o  = w_id_ex_q.aluop;
   assign bus.ex_alusel_o = w_id_ex_q.alusel;
   assign bus.ex_reg1_o   = w_id_ex_q.reg1;
   assign bus.ex_reg2_o   = w_id_ex_q.reg2;
   assign bus.ex_wd_o     = w_id_ex_q.wd;
   assign bus.ex_wreg_o   = w_id_ex_q.wreg;

   assign bus.mem_wd_o    = w_ex_mem_q.wd;
   assign bus.mem_wreg_o  = w_ex_mem_q.wreg;
   assign bus.mem_wdata_o = w_ex_mem_q.wdata;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_regs.sv
`default_nettype none
// ============================================================================
// tb_pipeline_regs : directed + scoreboard bench for the three stage registers
// Revision: 1.0
// ============================================================================
module tb_pipeline_regs;

   typedef struct packed {
      logic [15:0] id_pc;
      logic [15:0] id_inst;
      logic [7:0]  ex_aluop;
      logic [2:0]  ex_alusel;
      logic [15:0] ex_reg1;
      logic [15:0] ex_reg2;
      logic [3:0]  ex_wd;
      logic        ex_wreg;
      logic [3:0]  mem_wd;
      logic        mem_wreg;
      logic [15:0] mem_wdata;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   n_pass  = 0;
   int   n_total = 0;
   int   n_fail  = 0;
   out_t sb_q[$];
   out_t held;

   pipeline_regs_if bus ();

   pipeline_regs dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag, input out_t e);
      chk({tag, ".id_pc"},     32'(bus.id_pc_o),     32'(e.id_pc));
      chk({tag, ".id_inst"},   32'(bus.id_inst_o),   32'(e.id_inst));
      chk({tag, ".ex_aluop"},  32'(bus.ex_aluop_o),  32'(e.ex_aluop));
      chk({tag, ".ex_alusel"}, 32'(bus.ex_alusel_o), 32'(e.ex_alusel));
      chk({tag, ".ex_reg1"},   32'(bus.ex_reg1_o),   32'(e.ex_reg1));
      chk({tag, ".ex_reg2"},   32'(bus.ex_reg2_o),   32'(e.ex_reg2));
      chk({tag, ".ex_wd"},     32'(bus.ex_wd_o),     32'(e.ex_wd));
      chk({tag, ".ex_wreg"},   32'(bus.ex_wreg_o),   32'(e.ex_wreg));
      chk({tag, ".mem_wd"},    32'(bus.mem_wd_o),    32'(e.mem_wd));
      chk({tag, ".mem_wreg"},  32'(bus.mem_wreg_o),  32'(e.mem_wreg));
      chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata_o), 32'(e.mem_wdata));
   endtask

   // Reference: reset gives all-zero bubble, otherwise each stage copies its inputs.
   function automatic out_t predict();
      out_t e;
      e = '0;
      if (!rst) begin
         e.id_pc     = bus.if_pc_i;
         e.id_inst   = bus.if_inst_i;
         e.ex_aluop  = bus.id_aluop_i;
         e.ex_alusel = bus.id_alusel_i;
         e.ex_reg1   = bus.id_reg1_i;
         e.ex_reg2   = bus.id_reg2_i;
         e.ex_wd     = bus.id_wd_i;
         e.ex_wreg   = bus.id_wreg_i;
         e.mem_wd    = bus.ex_wd_i;
         e.mem_wreg  = bus.ex_wreg_i;
         e.mem_wdata = bus.ex_wdata_i;
      end
      return e;
   endfunction

   task automatic step(input string tag);
      sb_q.push_back(predict());
      @(posedge clk);
      #1;
      held = sb_q.pop_front();
      compare_all(tag, held);
   endtask

   task automatic drive_all(input logic [15:0] pc, input logic [15:0] inst,
                            input logic [7:0] aluop, input logic [2:0] alusel,
                            input logic [15:0] r1, input logic [15:0] r2,
                            input logic [3:0] wd, input logic wreg,
                            input logic [3:0] xwd, input logic xwreg,
                            input logic [15:0] xwdata);
      bus.if_pc_i     = pc;
      bus.if_inst_i   = inst;
      bus.id_aluop_i  = aluop;
      bus.id_alusel_i = alusel;
      bus.id_reg1_i   = r1;
      bus.id_reg2_i   = r2;
      bus.id_wd_i     = wd;
      bus.id_wreg_i   = wreg;
      bus.ex_wd_i     = xwd;
      bus.ex_wreg_i   = xwreg;
      bus.ex_wdata_i  = xwdata;
   endtask

   initial begin
      // Reset held for two edges with busy inputs: outputs must stay zero.
      rst = 1'b1;
      drive_all(16'h0005, 16'h3443, 8'hA5, 3'h5, 16'h1234, 16'h5678, 4'h9, 1'b1,
                4'h7, 1'b1, 16'hBEEF);
      step("rst_hold0");
      step("rst_hold1");

      rst = 1'b0;
      bus.if_pc_i   = 16'h0001;
      bus.if_inst_i = 16'h3443;
      #2;
      compare_all("pre_edge_hold", held);
      step("ifid_capture");

      drive_all(16'h0002, 16'h1111, 8'h25, 3'h1, 16'h0033, 16'h0029, 4'h3, 1'b1,
                4'h0, 1'b0, 16'h0000);
      step("idex_capture");
      bus.id_reg1_i  = 16'hDEAD;
      bus.id_aluop_i = 8'h7E;
      bus.id_wreg_i  = 1'b0;
      #2;
      compare_all("idex_midcycle", held);
      step("idex_next");

      bus.ex_wdata_i = 16'hFFFF;
      bus.ex_wd_i    = 4'hF;
      bus.ex_wreg_i  = 1'b1;
      step("exmem_capture");

      for (int i = 0; i < 10; i++) begin
         bus.if_pc_i = 16'(i);
         step($sformatf("stream%0d", i));
      end

      // Loaded pipeline; a mid-cycle reset must not act until the edge.
      drive_all(16'hA0A0, 16'h5A5A, 8'hFF, 3'h7, 16'h8001, 16'h7FFE, 4'hC, 1'b1,
                4'hB, 1'b1, 16'hC3C3);
      step("load_all");
      rst = 1'b1;
      #2;
      compare_all("rst_sync_only", held);
      step("rst_clear");
      rst = 1'b0;
      step("reload");

      // wd must pass through even with wreg low.
      for (int i = 0; i < 8; i++) begin
         drive_all(16'($urandom), 16'($urandom), 8'($urandom), 3'($urandom),
                   16'($urandom), 16'($urandom), 4'($urandom), 1'b0,
                   4'($urandom), 1'(i % 2), 16'($urandom));
         step($sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
